// File: rtl/dla_axi4_mgr_arb.sv
// Round-robin arbiter sharing one single-beat AXI4 manager between NUM_REQ requesters.
// Define DLA_AXI4_MGR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module dla_axi4_mgr_arb #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [NUM_REQ-1:0]                 wr_req_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  wr_data_i,
    input  logic [NUM_REQ-1:0]                 rd_req_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_REQ-1:0]                 wr_done_o,
    output logic [NUM_REQ-1:0]                 rd_done_o,
    output logic [AXI_DATA_WIDTH-1:0]          rd_data_o,
    output logic [1:0]                         mgr_req_o,
    output logic [AXI_ADDR_WIDTH-1:0]          mgr_wr_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]          mgr_rd_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]          mgr_wr_data_o,
    input  logic [1:0]                         mgr_rsp_i,
    input  logic [AXI_DATA_WIDTH-1:0]          mgr_rd_data_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // First set index at or above start, otherwise the lowest set index.
    function automatic logic [IdxW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IdxW-1:0]    start);
        logic [IdxW-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IdxW'(i) >= start)) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    logic [AXI_ADDR_WIDTH-1:0] wr_addr_arr [NUM_REQ];
    logic [AXI_DATA_WIDTH-1:0] wr_data_arr [NUM_REQ];
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign wr_addr_arr[i] = wr_addr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign wr_data_arr[i] = wr_data_i[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign rd_addr_arr[i] = rd_addr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    end

    state_e                    wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic [IdxW-1:0]           wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic [IdxW-1:0]           wr_start, rd_start;
    logic [NUM_REQ-1:0]        wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic                      wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

`ifdef DLA_AXI4_MGR_ARB_FIXED_PRIO_EN
    assign wr_start = '0;
    assign rd_start = '0;
`else
    logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    assign wr_start = wr_ptr_q;
    assign rd_start = rd_ptr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_state_q == StDone) begin
            wr_ptr_d = (wr_gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : wr_gnt_q + 1'b1;
        end
        if (rd_state_q == StDone) begin
            rd_ptr_d = (rd_gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : rd_gnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_pulse_d = 1'b0;
        wr_done_d  = '0;
        unique case (wr_state_q)
            StIdle: begin
                if (|wr_req_i) begin
                    wr_gnt_d   = pick(wr_req_i, wr_start);
                    wr_addr_d  = wr_addr_arr[wr_gnt_d];
                    wr_data_d  = wr_data_arr[wr_gnt_d];
                    wr_pulse_d = 1'b1;
                    wr_state_d = StBusy;
                end
            end
            StBusy: begin
                if (mgr_rsp_i[0]) begin
                    wr_done_d[wr_gnt_q] = 1'b1;
                    wr_state_d          = StDone;
                end
            end
            StDone:  wr_state_d = StIdle;
            default: wr_state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_addr_d  = rd_addr_q;
        rd_pulse_d = 1'b0;
        rd_done_d  = '0;
        unique case (rd_state_q)
            StIdle: begin
                if (|rd_req_i) begin
                    rd_gnt_d   = pick(rd_req_i, rd_start);
                    rd_addr_d  = rd_addr_arr[rd_gnt_d];
                    rd_pulse_d = 1'b1;
                    rd_state_d = StBusy;
                end
            end
            StBusy: begin
                if (mgr_rsp_i[1]) begin
                    rd_done_d[rd_gnt_q] = 1'b1;
                    rd_state_d          = StDone;
                end
            end
            StDone:  rd_state_d = StIdle;
            default: rd_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q <= StIdle;
            wr_gnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_pulse_q <= 1'b0;
            wr_done_q  <= '0;
            rd_state_q <= StIdle;
            rd_gnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_pulse_q <= 1'b0;
            rd_done_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_gnt_q   <= wr_gnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_pulse_q <= wr_pulse_d;
            wr_done_q  <= wr_done_d;
            rd_state_q <= rd_state_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_pulse_q <= rd_pulse_d;
            rd_done_q  <= rd_done_d;
        end
    end

    assign mgr_req_o     = {rd_pulse_q, wr_pulse_q};
    assign mgr_wr_addr_o = wr_addr_q;
    assign mgr_wr_data_o = wr_data_q;
    assign mgr_rd_addr_o = rd_addr_q;
    assign wr_done_o     = wr_done_q;
    assign rd_done_o     = rd_done_q;
    // The manager's read data lands one cycle after its response, i.e. in DONE.
    assign rd_data_o     = (|rd_done_q) ? mgr_rd_data_i : '0;

endmodule

// File: tb/tb_dla_axi4_mgr_arb.sv
// Directed self-checking bench for dla_axi4_mgr_arb (default round-robin build).
module tb_dla_axi4_mgr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [N-1:0]      wr_req_i, rd_req_i;
    logic [N*AW-1:0]   wr_addr_i, rd_addr_i;
    logic [N*DW-1:0]   wr_data_i;
    logic [N-1:0]      wr_done_o, rd_done_o;
    logic [DW-1:0]     rd_data_o;
    logic [1:0]        mgr_req_o;
    logic [AW-1:0]     mgr_wr_addr_o, mgr_rd_addr_o;
    logic [DW-1:0]     mgr_wr_data_o;
    logic [1:0]        mgr_rsp_i;
    logic [DW-1:0]     mgr_rd_data_i;

    int total = 0;
    int bad   = 0;

    dla_axi4_mgr_arb #(
        .NUM_REQ        (N),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .wr_req_i      (wr_req_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .wr_done_o     (wr_done_o),
        .rd_done_o     (rd_done_o),
        .rd_data_o     (rd_data_o),
        .mgr_req_o     (mgr_req_o),
        .mgr_wr_addr_o (mgr_wr_addr_o),
        .mgr_rd_addr_o (mgr_rd_addr_o),
        .mgr_wr_data_o (mgr_wr_data_o),
        .mgr_rsp_i     (mgr_rsp_i),
        .mgr_rd_data_i (mgr_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn_i        = 1'b0;
        wr_req_i      = '0;
        rd_req_i      = '0;
        wr_addr_i     = '0;
        rd_addr_i     = '0;
        wr_data_i     = '0;
        mgr_rsp_i     = '0;
        mgr_rd_data_i = '0;
        for (int i = 0; i < N; i++) begin
            wr_addr_i[i*AW +: AW] = 32'h100 * (i + 1);
            wr_data_i[i*DW +: DW] = 64'hA0 + 64'(i);
            rd_addr_i[i*AW +: AW] = 32'h2000 + 32'h10 * i;
        end
        step();
        step();
        chk("rst_mgr_req", 64'(mgr_req_o), 64'h0);
        chk("rst_wr_addr", 64'(mgr_wr_addr_o), 64'h0);
        chk("rst_rd_addr", 64'(mgr_rd_addr_o), 64'h0);
        chk("rst_wr_data", mgr_wr_data_o, 64'h0);
        chk("rst_done", 64'({rd_done_o, wr_done_o}), 64'h0);
        rstn_i = 1'b1;
        step();

        // Fairness: all four held, each drops after its completion.
        wr_req_i = 4'b1111;
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_req", 64'(mgr_req_o), 64'h1);
            chk("rr_addr", 64'(mgr_wr_addr_o), 64'(32'h100 * (k + 1)));
            step();
            chk("rr_req_clr", 64'(mgr_req_o), 64'h0);
            mgr_rsp_i = 2'b01;
            step();
            mgr_rsp_i = 2'b00;
            chk("rr_done", 64'(wr_done_o), 64'(4'b0001 << k));
            wr_req_i[k] = 1'b0;
            step();
        end
        wr_req_i = 4'b1001;
        step();
        chk("wrap_addr", 64'(mgr_wr_addr_o), 64'h100);
        step();
        mgr_rsp_i = 2'b01;
        step();
        mgr_rsp_i = 2'b00;
        chk("wrap_done", 64'(wr_done_o), 64'h1);
        wr_req_i = '0;
        step();

        // Single write with a 5-cycle manager delay.
        wr_addr_i[2*AW +: AW] = 32'h1000;
        wr_data_i[2*DW +: DW] = 64'h55;
        wr_req_i = 4'b0100;
        step();
        chk("wr_req", 64'(mgr_req_o), 64'h1);
        chk("wr_addr", 64'(mgr_wr_addr_o), 64'h1000);
        chk("wr_data", mgr_wr_data_o, 64'h55);
        step();
        chk("wr_req_clr", 64'(mgr_req_o), 64'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("wr_hold", 64'({wr_done_o, mgr_wr_addr_o}), 64'h1000);
        end
        mgr_rsp_i = 2'b01;
        step();
        mgr_rsp_i = 2'b00;
        chk("wr_done", 64'(wr_done_o), 64'h4);
        wr_req_i = '0;
        step();
        chk("wr_done_clr", 64'(wr_done_o), 64'h0);

        // Read data lands with rd_done.
        rd_req_i = 4'b0010;
        step();
        chk("rd_req", 64'(mgr_req_o), 64'h2);
        chk("rd_addr", 64'(mgr_rd_addr_o), 64'h2010);
        step();
        mgr_rsp_i = 2'b10;
        step();
        mgr_rsp_i     = 2'b00;
        mgr_rd_data_i = 64'hDEADBEEF;
        #1;
        chk("rd_done", 64'(rd_done_o), 64'h2);
        chk("rd_data", rd_data_o, 64'hDEADBEEF);
        rd_req_i = '0;
        step();
        chk("rd_done_clr", 64'(rd_done_o), 64'h0);

        // Concurrent directions, read completes first.
        wr_req_i = 4'b0001;
        rd_req_i = 4'b0100;
        step();
        chk("cc_req", 64'(mgr_req_o), 64'h3);
        chk("cc_rd_addr", 64'(mgr_rd_addr_o), 64'h2020);
        chk("cc_wr_addr", 64'(mgr_wr_addr_o), 64'h100);
        step();
        mgr_rsp_i = 2'b10;
        step();
        mgr_rsp_i = 2'b00;
        chk("cc_done_rd", 64'({rd_done_o, wr_done_o}), 64'h40);
        rd_req_i = '0;
        step();
        mgr_rsp_i = 2'b01;
        step();
        mgr_rsp_i = 2'b00;
        chk("cc_done_wr", 64'({rd_done_o, wr_done_o}), 64'h01);
        wr_req_i = '0;
        step();

        // Spurious responses while both idle.
        mgr_rsp_i = 2'b11;
        step();
        chk("sp_done", 64'({rd_done_o, wr_done_o}), 64'h0);
        step();
        mgr_rsp_i = 2'b00;
        chk("sp_done2", 64'({rd_done_o, wr_done_o, mgr_req_o}), 64'h0);

        // Reset while write is busy; pointer must restart at 0.
        wr_req_i = 4'b0010;
        step();
        chk("mr_req", 64'(mgr_req_o), 64'h1);
        chk("mr_addr", 64'(mgr_wr_addr_o), 64'h200);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("mr_rst_req", 64'(mgr_req_o), 64'h0);
        chk("mr_rst_addr", 64'(mgr_wr_addr_o), 64'h0);
        chk("mr_rst_data", mgr_wr_data_o, 64'h0);
        wr_req_i = '0;
        step();
        rstn_i   = 1'b1;
        wr_req_i = 4'b1110;
        wr_req_i[0] = 1'b1;
        step();
        chk("mr_new_req", 64'(mgr_req_o), 64'h1);
        chk("mr_new_addr", 64'(mgr_wr_addr_o), 64'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
